mem_port_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: the riscv_core load/store

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/arb_pick.sv | 21 ++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DMA  = 1'b1;

    localparam int          WCNT_W   = 4;
    localparam logic [WCNT_W-1:0] WCNT_SAT = 4'd15;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select: core first, DMA when core idle or DMA is starving.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic c_req,
    input  logic d_req,
    input  logic starve,
    output logic any_req,
    output logic winner
);

    assign any_req = c_req | d_req;

    always_comb begin
        winner = REQ_CORE;
        if (d_req && (starve || !c_req)) begin
            winner = REQ_DMA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port data memory: one access in flight,
// core priority with bounded DMA starvation, read data returned with a valid pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdat,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdat,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_rd_en,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wr_dat,
    input  logic [DW-1:0] mem_rd_dat
);

    arb_state_t          state_reg;
    logic                owner_reg;
    logic                we_reg;
    logic [AW-1:0]       addr_reg;
    logic [DW-1:0]       wdat_reg;
    logic [2:0]          lat_cnt_reg;
    logic [WCNT_W-1:0]   wait_cnt_reg;
    logic [DW-1:0]       rdata_reg [2];

    logic any_req;
    logic winner;
    logic starve;
    logic issue;
    logic rd_done;
    logic [1:0] gnt_vec;
    logic [1:0] rvalid_vec;

    assign starve = (wait_cnt_reg >= WCNT_W'(MAX_WAIT));

    arb_pick u_pick (
        .c_req   (c_req),
        .d_req   (d_req),
        .starve  (starve),
        .any_req (any_req),
        .winner  (winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            owner_reg   <= REQ_CORE;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdat_reg    <= '0;
            lat_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        owner_reg <= winner;
                        we_reg    <= (winner == REQ_DMA) ? d_we   : c_we;
                        addr_reg  <= (winner == REQ_DMA) ? d_addr : c_addr;
                        wdat_reg  <= (winner == REQ_DMA) ? d_wdat : c_wdat;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_reg) begin
                        state_reg <= IDLE;
                    end else begin
                        lat_cnt_reg <= 3'(RD_LAT - 1);
                        state_reg   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt_reg == 3'd0) begin
                        state_reg <= IDLE;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 3'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Counts only the cycles DMA actually loses an arbitration to the core.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_reg <= '0;
        end else if (!d_req || d_gnt) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == IDLE && any_req && winner == REQ_CORE &&
                     wait_cnt_reg != WCNT_SAT) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

    assign issue   = (state_reg == ISSUE);
    assign rd_done = (state_reg == WAIT) && (lat_cnt_reg == 3'd0);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign gnt_vec[gi]    = issue   && (owner_reg == 1'(gi));
            assign rvalid_vec[gi] = rd_done && (owner_reg == 1'(gi));

            // Holds the last delivered word; the live word is forwarded during rvalid.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_reg[gi] <= '0;
                end else if (rvalid_vec[gi]) begin
                    rdata_reg[gi] <= mem_rd_dat;
                end
            end
        end
    endgenerate

    assign c_gnt    = gnt_vec[REQ_CORE];
    assign d_gnt    = gnt_vec[REQ_DMA];
    assign c_rvalid = rvalid_vec[REQ_CORE];
    assign d_rvalid = rvalid_vec[REQ_DMA];
    assign c_rdata  = c_rvalid ? mem_rd_dat : rdata_reg[REQ_CORE];
    assign d_rdata  = d_rvalid ? mem_rd_dat : rdata_reg[REQ_DMA];

    assign mem_rd_en  = issue && !we_reg;
    assign mem_wr_en  = issue &&  we_reg;
    assign mem_addr   = issue ? addr_reg : '0;
    assign mem_wr_dat = issue ? wdat_reg : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance a uses RD_LAT=1, instance b uses RD_LAT=3, each with its own memory model.
module tb_mem_port_arbiter;

    localparam logic [31:0] SENT = 32'hBAD0_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        a_c_req, a_c_we, a_c_gnt, a_c_rvalid;
    logic [31:0] a_c_addr, a_c_wdat, a_c_rdata;
    logic        a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
    logic [31:0] a_d_addr, a_d_wdat, a_d_rdata;
    logic        a_mem_rd_en, a_mem_wr_en;
    logic [31:0] a_mem_addr, a_mem_wr_dat, a_mem_rd_dat;

    logic        b_c_req, b_c_we, b_c_gnt, b_c_rvalid;
    logic [31:0] b_c_addr, b_c_wdat, b_c_rdata;
    logic        b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic [31:0] b_d_addr, b_d_wdat, b_d_rdata;
    logic        b_mem_rd_en, b_mem_wr_en;
    logic [31:0] b_mem_addr, b_mem_wr_dat, b_mem_rd_dat;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .MAX_WAIT(4)) dut_a (
        .clk(clk), .reset(reset),
        .c_req(a_c_req), .c_we(a_c_we), .c_addr(a_c_addr), .c_wdat(a_c_wdat),
        .c_gnt(a_c_gnt), .c_rvalid(a_c_rvalid), .c_rdata(a_c_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdat(a_d_wdat),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_rd_en(a_mem_rd_en), .mem_wr_en(a_mem_wr_en), .mem_addr(a_mem_addr),
        .mem_wr_dat(a_mem_wr_dat), .mem_rd_dat(a_mem_rd_dat)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .MAX_WAIT(4)) dut_b (
        .clk(clk), .reset(reset),
        .c_req(b_c_req), .c_we(b_c_we), .c_addr(b_c_addr), .c_wdat(b_c_wdat),
        .c_gnt(b_c_gnt), .c_rvalid(b_c_rvalid), .c_rdata(b_c_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdat(b_d_wdat),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_rd_en(b_mem_rd_en), .mem_wr_en(b_mem_wr_en), .mem_addr(b_mem_addr),
        .mem_wr_dat(b_mem_wr_dat), .mem_rd_dat(b_mem_rd_dat)
    );

    // Memory models: read data appears RD_LAT cycles after the strobe, sentinel otherwise.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] pa;
    logic [31:0] pb [3];

    always @(posedge clk) begin
        if (a_mem_wr_en) mem_a[a_mem_addr[7:0]] <= a_mem_wr_dat;
        pa <= a_mem_rd_en ? mem_a[a_mem_addr[7:0]] : SENT;
        if (b_mem_wr_en) mem_b[b_mem_addr[7:0]] <= b_mem_wr_dat;
        pb[0] <= b_mem_rd_en ? mem_b[b_mem_addr[7:0]] : SENT;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign a_mem_rd_dat = pa;
    assign b_mem_rd_dat = pb[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt_gnt;
        int cnt_rd;
        int cnt_rv;
        logic exp_c;
        logic exp_d;
        logic [31:0] exp_addr;

        a_c_req = 0; a_c_we = 0; a_c_addr = 0; a_c_wdat = 0;
        a_d_req = 0; a_d_we = 0; a_d_addr = 0; a_d_wdat = 0;
        b_c_req = 0; b_c_we = 0; b_c_addr = 0; b_c_wdat = 0;
        b_d_req = 0; b_d_we = 0; b_d_addr = 0; b_d_wdat = 0;

        // Reset state
        step(); step(); step();
        chk("rst_c_gnt", a_c_gnt, 0);
        chk("rst_d_gnt", a_d_gnt, 0);
        chk("rst_mem_rd_en", a_mem_rd_en, 0);
        chk("rst_mem_wr_en", a_mem_wr_en, 0);
        chk("rst_mem_addr", a_mem_addr, 0);
        chk("rst_c_rdata", a_c_rdata, 0);
        reset = 0;
        $display("reset released");

        // 1: core write
        a_c_req = 1; a_c_we = 1; a_c_addr = 32'h10; a_c_wdat = 32'hDEADBEEF;
        step();
        chk("t1_c_gnt", a_c_gnt, 1);
        chk("t1_wr_en", a_mem_wr_en, 1);
        chk("t1_rd_en", a_mem_rd_en, 0);
        chk("t1_addr", a_mem_addr, 32'h10);
        chk("t1_wdat", a_mem_wr_dat, 32'hDEADBEEF);
        a_c_req = 0;
        step();
        chk("t1_c_rvalid", a_c_rvalid, 0);
        chk("t1_gnt_off", a_c_gnt, 0);
        chk("t1_wr_en_off", a_mem_wr_en, 0);
        $display("t1 core write addr=10 done");

        // 2: core read back, RD_LAT=1
        a_c_req = 1; a_c_we = 0; a_c_addr = 32'h10;
        step();
        chk("t2_c_gnt", a_c_gnt, 1);
        chk("t2_rd_en", a_mem_rd_en, 1);
        chk("t2_rvalid_early", a_c_rvalid, 0);
        a_c_req = 0;
        step();
        chk("t2_c_rvalid", a_c_rvalid, 1);
        chk("t2_c_rdata", a_c_rdata, 32'hDEADBEEF);
        chk("t2_mem_addr_off", a_mem_addr, 0);
        step();
        chk("t2_rvalid_off", a_c_rvalid, 0);
        chk("t2_rdata_held", a_c_rdata, 32'hDEADBEEF);
        $display("t2 core read addr=10 data=%h", a_c_rdata);

        // 3: both requesting writes continuously; DMA wins every fifth grant
        a_c_req = 1; a_c_we = 1; a_c_addr = 32'h20; a_c_wdat = 32'h1;
        a_d_req = 1; a_d_we = 1; a_d_addr = 32'h30; a_d_wdat = 32'h2;
        for (int k = 1; k <= 19; k++) begin
            step();
            exp_c = (k % 2 == 1) && (((k - 1) / 2) % 5 != 4);
            exp_d = (k % 2 == 1) && (((k - 1) / 2) % 5 == 4);
            exp_addr = exp_c ? 32'h20 : (exp_d ? 32'h30 : 32'h0);
            chk($sformatf("t3_c_gnt_k%0d", k), a_c_gnt, exp_c);
            chk($sformatf("t3_d_gnt_k%0d", k), a_d_gnt, exp_d);
            chk($sformatf("t3_addr_k%0d", k), a_mem_addr, exp_addr);
            $display("t3 k=%0d c_gnt=%0b d_gnt=%0b", k, a_c_gnt, a_d_gnt);
        end
        a_c_req = 0; a_d_req = 0;
        step();
        chk("t3_idle_c", a_c_gnt, 0);
        step();
        chk("t3_no_extra", a_c_gnt | a_d_gnt, 0);

        // 5: core drops request right after capture
        a_c_req = 1; a_c_we = 0; a_c_addr = 32'h10;
        cnt_gnt = 0; cnt_rd = 0; cnt_rv = 0;
        step();
        a_c_req = 0;
        for (int k = 0; k < 5; k++) begin
            cnt_gnt += int'(a_c_gnt);
            cnt_rd  += int'(a_mem_rd_en);
            cnt_rv  += int'(a_c_rvalid);
            if (k < 4) step();
        end
        chk("t5_gnt_count", cnt_gnt, 1);
        chk("t5_rd_en_count", cnt_rd, 1);
        chk("t5_rvalid_count", cnt_rv, 1);
        chk("t5_rdata", a_c_rdata, 32'hDEADBEEF);
        $display("t5 dropped req gnt=%0d rd_en=%0d rvalid=%0d", cnt_gnt, cnt_rd, cnt_rv);

        // 6: RD_LAT=3 DMA read, core request arrives during WAIT
        b_d_req = 1; b_d_we = 1; b_d_addr = 32'h50; b_d_wdat = 32'hCAFEF00D;
        step();
        chk("t6_wr_gnt", b_d_gnt, 1);
        chk("t6_wr_en", b_mem_wr_en, 1);
        chk("t6_wdat", b_mem_wr_dat, 32'hCAFEF00D);
        b_d_req = 0;
        step();
        chk("t6_wr_gnt_off", b_d_gnt, 0);
        b_d_req = 1; b_d_we = 0;
        step();
        chk("t6_rd_gnt", b_d_gnt, 1);
        chk("t6_rd_en", b_mem_rd_en, 1);
        b_d_req = 0;
        b_c_req = 1; b_c_we = 0; b_c_addr = 32'h50;
        step();
        chk("t6_rv_c3", b_d_rvalid, 0);
        chk("t6_cgnt_c3", b_c_gnt, 0);
        step();
        chk("t6_rv_c4", b_d_rvalid, 0);
        chk("t6_cgnt_c4", b_c_gnt, 0);
        step();
        chk("t6_rv_c5", b_d_rvalid, 1);
        chk("t6_rdata_c5", b_d_rdata, 32'hCAFEF00D);
        chk("t6_cgnt_c5", b_c_gnt, 0);
        step();
        chk("t6_rv_c6", b_d_rvalid, 0);
        chk("t6_cgnt_c6", b_c_gnt, 0);
        chk("t6_rdata_held", b_d_rdata, 32'hCAFEF00D);
        step();
        chk("t6_cgnt_c7", b_c_gnt, 1);
        chk("t6_c_rd_en", b_mem_rd_en, 1);
        b_c_req = 0;
        step();
        chk("t6_crv_c8", b_c_rvalid, 0);
        step();
        chk("t6_crv_c9", b_c_rvalid, 0);
        step();
        chk("t6_crv_c10", b_c_rvalid, 1);
        chk("t6_c_rdata", b_c_rdata, 32'hCAFEF00D);
        $display("t6 dma read lat3 data=%h core data=%h", b_d_rdata, b_c_rdata);
        step();

        // 4: reset during WAIT of a DMA read
        b_d_req = 1; b_d_we = 0; b_d_addr = 32'h50;
        step();
        chk("t4_d_gnt", b_d_gnt, 1);
        b_d_req = 0;
        step();
        reset = 1;
        #1;
        chk("t4_rv_async", b_d_rvalid, 0);
        chk("t4_drdata_clr", b_d_rdata, 0);
        chk("t4_rd_en_off", b_mem_rd_en, 0);
        step();
        chk("t4_d_gnt_rst", b_d_gnt, 0);
        chk("t4_addr_rst", b_mem_addr, 0);
        chk("t4_crdata_rst", b_c_rdata, 0);
        reset = 0;
        step();
        chk("t4_rv_c5", b_d_rvalid, 0);
        step();
        chk("t4_rv_c6", b_d_rvalid, 0);
        b_d_req = 1;
        step();
        chk("t4_post_gnt", b_d_gnt, 1);
        b_d_req = 0;
        step(); step();
        chk("t4_post_rv_early", b_d_rvalid, 0);
        step();
        chk("t4_post_rv", b_d_rvalid, 1);
        chk("t4_post_rdata", b_d_rdata, 32'hCAFEF00D);
        $display("t4 reset mid-read then dma read data=%h", b_d_rdata);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
